// File: rtl/vip_frame_cfg_ctrl_if.sv
// Key, frame and init-status signals in; committed VIP configuration, SDRAM gate and status out.
interface vip_frame_cfg_ctrl_if;
  logic       init_done;
  logic       key_flag;
  logic [1:0] key_value;
  logic       per_frame_vsync;
  logic [2:0] vip_mode;
  logic [3:0] sobel_grade;
  logic [7:0] sobel_threshold;
  logic       frame_we_gate;
  logic [7:0] frame_cnt;
  logic       cfg_pending;
  logic       stall;

  modport slave (
    input  init_done, key_flag, key_value, per_frame_vsync,
    output vip_mode, sobel_grade, sobel_threshold, frame_we_gate, frame_cnt, cfg_pending, stall
  );

  modport master (
    output init_done, key_flag, key_value, per_frame_vsync,
    input  vip_mode, sobel_grade, sobel_threshold, frame_we_gate, frame_cnt, cfg_pending, stall
  );
endinterface

// File: rtl/vip_frame_cfg_ctrl.sv
// Frame-synchronous VIP config controller: key edits go to shadow regs and commit at start-of-frame;
// the SDRAM write gate admits only whole frames after init, and a vsync stall is detected.
//
//   state    | meaning
//   ---------+--------------------------------------------------------
//   IDLE     | init not done, gate closed
//   WAIT_SOF | init done, waiting for the first full frame
//   ACTIVE   | frames admitted to SDRAM, stall timer running
//   STALL    | no SOF within timeout, gate closed, shadow commits live
module vip_frame_cfg_ctrl #(
  parameter int          MODE_NUM    = 5,
  parameter int          GRADE_MAX   = 15,
  parameter int          GRADE_INIT  = 8,
  parameter int          THRESH_BASE = 8,
  parameter int          THRESH_STEP = 8,
  parameter logic [23:0] TIMEOUT_CYC = 24'd4_000_000
) (
  input logic                 clk,
  input logic                 rst_n,
  vip_frame_cfg_ctrl_if.slave bus
);

  localparam logic [3:0] GMAX  = 4'(GRADE_MAX);
  localparam logic [3:0] GINIT = 4'(GRADE_INIT);
  localparam logic [2:0] MLAST = 3'(MODE_NUM - 1);

  typedef enum logic [1:0] {IDLE, WAIT_SOF, ACTIVE, STALL} state_t;

  state_t      state, state_nx;
  logic        vs_q, sof, commit;
  logic [2:0]  mode_sh, mode_nx, mode_q, mode_c_nx;
  logic [3:0]  grade_sh, grade_nx, grade_q, grade_c_nx;
  logic [7:0]  thr_q, frame_q;
  logic        pending_q;
  logic [23:0] tmr_q;
  logic        tmr_load, tmr_run, tmr_done, frame_inc;

  function automatic logic [7:0] thresh_of(input logic [3:0] g);
    logic [11:0] t;
    t = 12'(THRESH_BASE) + 12'(g) * 12'(THRESH_STEP);
    return (t > 12'd255) ? 8'hFF : t[7:0];
  endfunction

  assign sof      = bus.per_frame_vsync & ~vs_q;
  assign commit   = sof | (state == STALL);
  assign tmr_done = (tmr_q == 24'd0);

  always_comb begin
    mode_nx  = mode_sh;
    grade_nx = grade_sh;
    if (bus.key_flag) begin
      case (bus.key_value)
        2'b01:   if (grade_sh != GMAX) grade_nx = grade_sh + 4'd1;
        2'b10:   if (grade_sh != 4'd0) grade_nx = grade_sh - 4'd1;
        2'b11:   mode_nx = (mode_sh == MLAST) ? 3'd0 : mode_sh + 3'd1;
        default: ;
      endcase
    end
    mode_c_nx  = commit ? mode_nx  : mode_q;
    grade_c_nx = commit ? grade_nx : grade_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    tmr_load  = 1'b0;
    tmr_run   = 1'b0;
    frame_inc = 1'b0;
    case (state)
      IDLE: if (bus.init_done) state_nx = WAIT_SOF;
      WAIT_SOF, STALL: begin
        if (sof) begin
          state_nx  = ACTIVE;
          tmr_load  = 1'b1;
          frame_inc = 1'b1;
        end
      end
      ACTIVE: begin
        if (sof) begin
          tmr_load  = 1'b1;
          frame_inc = 1'b1;
        end else if (tmr_done) begin
          state_nx = STALL;
        end else begin
          tmr_run = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
    // Losing init beats a coincident SOF: no admit, no count
    if (!bus.init_done) begin
      state_nx  = IDLE;
      tmr_load  = 1'b0;
      tmr_run   = 1'b0;
      frame_inc = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q      <= 1'b0;
      mode_sh   <= 3'd0;
      grade_sh  <= GINIT;
      mode_q    <= 3'd0;
      grade_q   <= GINIT;
      thr_q     <= thresh_of(GINIT);
      pending_q <= 1'b0;
      frame_q   <= 8'd0;
      tmr_q     <= 24'd0;
    end else begin
      vs_q      <= bus.per_frame_vsync;
      mode_sh   <= mode_nx;
      grade_sh  <= grade_nx;
      mode_q    <= mode_c_nx;
      grade_q   <= grade_c_nx;
      thr_q     <= thresh_of(grade_c_nx);
      pending_q <= (mode_nx != mode_c_nx) || (grade_nx != grade_c_nx);
      if (frame_inc) frame_q <= frame_q + 8'd1;
      // Down-counter from SOF; terminal count at zero holds until reloaded
      if (tmr_load)                tmr_q <= TIMEOUT_CYC - 24'd1;
      else if (tmr_run && !tmr_done) tmr_q <= tmr_q - 24'd1;
    end
  end

  assign bus.vip_mode        = mode_q;
  assign bus.sobel_grade     = grade_q;
  assign bus.sobel_threshold = thr_q;
  assign bus.frame_we_gate   = (state == ACTIVE);
  assign bus.frame_cnt       = frame_q;
  assign bus.cfg_pending     = pending_q;
  assign bus.stall           = (state == STALL);

endmodule

// File: tb/tb_vip_frame_cfg_ctrl.sv
// Scoreboard bench: driver updates a frame-level reference model each cycle and queues the
// expected outputs; a monitor pops and compares them after every rising edge.
module tb_vip_frame_cfg_ctrl;
  localparam int MODE_NUM   = 5;
  localparam int GRADE_MAX  = 15;
  localparam int GRADE_INIT = 8;
  localparam int TO         = 100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  vip_frame_cfg_ctrl_if bus();

  vip_frame_cfg_ctrl #(.TIMEOUT_CYC(24'd100)) u_dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int mode; int grade; int thr; int gate; int cnt; int pend; int stall;
  } exp_t;
  exp_t exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int key_pct = 10;
  bit cur_init = 1'b0;

  // reference model state
  int sh_m, sh_g, c_m, c_g, m_frames, m_since;
  bit m_vs, m_armed, m_adm, m_stalled;

  function automatic int thr_of(int g);
    int t;
    t = 8 + g * 8;
    return (t > 255) ? 255 : t;
  endfunction

  task automatic model(bit rst, bit init, bit kf, int kv, bit vs);
    bit sof;
    if (rst) begin
      sh_m = 0; sh_g = GRADE_INIT; c_m = 0; c_g = GRADE_INIT;
      m_frames = 0; m_since = 0; m_vs = 0; m_armed = 0; m_adm = 0; m_stalled = 0;
    end else begin
      sof  = vs && !m_vs;
      m_vs = vs;
      if (kf) begin
        if (kv == 1 && sh_g < GRADE_MAX) sh_g++;
        else if (kv == 2 && sh_g > 0)    sh_g--;
        else if (kv == 3)                sh_m = (sh_m + 1) % MODE_NUM;
      end
      if (sof || m_stalled) begin
        c_m = sh_m;
        c_g = sh_g;
      end
      if (!init) begin
        m_armed = 0; m_adm = 0; m_stalled = 0;
      end else if (!m_armed) begin
        m_armed = 1;
      end else if (sof) begin
        m_adm = 1; m_stalled = 0; m_since = 0;
        m_frames = (m_frames + 1) % 256;
      end else if (m_adm) begin
        m_since++;
        if (m_since >= TO) begin
          m_adm = 0;
          m_stalled = 1;
        end
      end
    end
  endtask

  task automatic step(bit rst, bit init, bit kf, int kv, bit vs);
    exp_t e;
    @(negedge clk);
    rst_n               = !rst;
    bus.init_done       = init;
    bus.key_flag        = kf;
    bus.key_value       = 2'(kv);
    bus.per_frame_vsync = vs;
    model(rst, init, kf, kv, vs);
    e.mode  = c_m;
    e.grade = c_g;
    e.thr   = thr_of(c_g);
    e.gate  = int'(m_adm);
    e.cnt   = m_frames;
    e.pend  = int'((sh_m != c_m) || (sh_g != c_g));
    e.stall = int'(m_stalled);
    exp_q.push_back(e);
  endtask

  task automatic run(int n, bit vs, bit sof_key);
    bit kf;
    int kv;
    for (int i = 0; i < n; i++) begin
      kf = ($urandom_range(99) < key_pct);
      kv = $urandom_range(3);
      if (sof_key && i == 0) begin
        kf = 1'b1;
        kv = $urandom_range(3, 1);
      end
      step(1'b0, cur_init, kf, kv, vs);
    end
  endtask

  task automatic keys(int n, int kv, bit vs);
    for (int i = 0; i < n; i++) step(1'b0, cur_init, 1'b1, kv, vs);
  endtask

  task automatic frame(int hi, int lo, bit sof_key);
    run(hi, 1'b1, sof_key);
    run(lo, 1'b0, 1'b0);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_tests++;
      if (int'(bus.vip_mode) != e.mode || int'(bus.sobel_grade) != e.grade ||
          int'(bus.sobel_threshold) != e.thr || int'(bus.frame_we_gate) != e.gate ||
          int'(bus.frame_cnt) != e.cnt || int'(bus.cfg_pending) != e.pend ||
          int'(bus.stall) != e.stall) begin
        n_fail++;
        $display("FAIL outputs t=%0t got mode=%0d grade=%0d thr=%0d gate=%0d cnt=%0d pend=%0d stall=%0d expected mode=%0d grade=%0d thr=%0d gate=%0d cnt=%0d pend=%0d stall=%0d",
                 $time, bus.vip_mode, bus.sobel_grade, bus.sobel_threshold, bus.frame_we_gate,
                 bus.frame_cnt, bus.cfg_pending, bus.stall,
                 e.mode, e.grade, e.thr, e.gate, e.cnt, e.pend, e.stall);
      end
    end
  end

  initial begin
    bus.init_done = 1'b0;
    bus.key_flag = 1'b0;
    bus.key_value = 2'b00;
    bus.per_frame_vsync = 1'b0;

    // reset, then vsync with init low: nothing admitted
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 0, 1'b0);
    cur_init = 1'b0;
    frame(20, 10, 1'b0);
    cur_init = 1'b1;
    run(5, 1'b0, 1'b0);
    for (int f = 0; f < 3; f++) frame(50, 30, 1'b0);

    // grade +3 mid-frame, mode wrap, grade saturation both ways
    key_pct = 0;
    run(5, 1'b1, 1'b0);
    keys(3, 1, 1'b1);
    run(40, 1'b1, 1'b0);
    run(30, 1'b0, 1'b0);
    run(5, 1'b1, 1'b0);
    keys(5, 3, 1'b1);
    keys(10, 1, 1'b1);
    run(20, 1'b0, 1'b0);
    frame(30, 20, 1'b0);
    keys(20, 2, 1'b1);
    run(20, 1'b0, 1'b0);
    frame(30, 20, 1'b1);
    frame(30, 20, 1'b1);

    // vsync stops: stall, keys commit live, then resume
    key_pct = 8;
    run(150, 1'b0, 1'b0);
    keys(2, 1, 1'b0);
    run(10, 1'b0, 1'b0);
    for (int f = 0; f < 3; f++) frame(40, 20, 1'b0);

    // init lost on a SOF edge, regained with vsync high
    run(1, 1'b0, 1'b0);
    cur_init = 1'b0;
    run(30, 1'b1, 1'b0);
    cur_init = 1'b1;
    run(20, 1'b1, 1'b0);
    run(30, 1'b0, 1'b0);
    for (int f = 0; f < 3; f++) frame(40, 20, 1'b1);

    // reset mid-frame
    run(20, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 0, 1'b1);
    run(20, 1'b1, 1'b0);
    run(20, 1'b0, 1'b0);
    for (int f = 0; f < 3; f++) frame(40, 20, 1'b0);

    // randomized frame timing incl. occasional stalls and init drops
    key_pct = 15;
    for (int f = 0; f < 30; f++) begin
      if ($urandom_range(9) == 0) cur_init = 1'b0;
      else cur_init = 1'b1;
      frame($urandom_range(60, 5), $urandom_range(120, 2), $urandom_range(1));
    end

    @(negedge clk);
    @(negedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain got %0d queued expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
